// File: rtl/scs8hd_latch_bank_wr_ctrl_pkg.sv
// Shared definitions for the latch-bank write controller: FSM state encoding
// and the helper that sizes the phase timer.
package scs8hd_latch_bank_wr_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_OPEN  = 2'd2,
    ST_HOLD  = 2'd3
  } wr_state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Timer must hold the longest phase length without wrapping.
  function automatic int cnt_width(input int s, input int p, input int h);
    return $clog2(max3(s, p, h) + 1);
  endfunction

endpackage

// File: rtl/scs8hd_latch_bank_wr_ctrl_timer.sv
// Loadable down-counter that times each setup/open/hold phase.
// Done is asserted while the count sits at 1; it never decrements below 1.
module scs8hd_latch_wr_timer #(
  parameter int CW = 1
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          i_load,
  input  logic [CW-1:0] i_value,
  output logic          o_done
);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_value;
    end else if (r_cnt > CW'(1)) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_done = (r_cnt == CW'(1));

endmodule

// File: rtl/scs8hd_latch_bank_wr_ctrl.sv
// Write controller for a bank of active-low-gate D latches: drives a shared D bus and
// one registered gate per entry through a setup / open / hold sequence.
module scs8hd_latch_bank_wr_ctrl
  import scs8hd_latch_bank_wr_ctrl_pkg::*;
#(
  parameter int   DEPTH     = 8,
  parameter int   WIDTH     = 8,
  parameter int   SETUP_CYC = 1,
  parameter int   PULSE_CYC = 1,
  parameter int   HOLD_CYC  = 1,
  localparam int  AW        = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             WR_VALID,
  output logic             WR_READY,
  input  logic [AW-1:0]    WR_ADDR,
  input  logic [WIDTH-1:0] WR_DATA,
  output logic             WR_ERR,
  output logic [WIDTH-1:0] D_BUS,
  output logic [DEPTH-1:0] GATEN
);

  localparam int               CW               = cnt_width(SETUP_CYC, PULSE_CYC, HOLD_CYC);
  localparam logic [DEPTH-1:0] GATEN_ALL_CLOSED = '1;
  localparam logic [AW:0]      DEPTH_LIM        = DEPTH[AW:0];

  wr_state_e        r_state, w_state_next;
  logic [AW-1:0]    r_addr, w_addr_next;
  logic [WIDTH-1:0] r_dbus, w_dbus_next;
  logic [DEPTH-1:0] r_gaten, w_gaten_next;
  logic             r_ready, w_ready_next;
  logic             r_err, w_err_next;
  logic             w_load, w_done, w_accept, w_addr_ok;
  logic [CW-1:0]    w_load_val;
  logic [DEPTH-1:0] w_sel;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_sel
      assign w_sel[gi] = (r_addr == AW'(gi));
    end
  endgenerate

  assign w_accept  = WR_VALID & r_ready;
  assign w_addr_ok = ({1'b0, WR_ADDR} < DEPTH_LIM);

  scs8hd_latch_wr_timer #(.CW(CW)) u_timer (
    .CLK     (CLK),
    .RESET   (RESET),
    .i_load  (w_load),
    .i_value (w_load_val),
    .o_done  (w_done)
  );

  // Gate pattern is computed one cycle ahead so GATEN leaves a flop with no decode after it.
  always_comb begin
    w_state_next = r_state;
    w_addr_next  = r_addr;
    w_dbus_next  = r_dbus;
    w_gaten_next = GATEN_ALL_CLOSED;
    w_err_next   = 1'b0;
    w_load       = 1'b0;
    w_load_val   = CW'(SETUP_CYC);
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_addr_ok) begin
            w_addr_next  = WR_ADDR;
            w_dbus_next  = WR_DATA;
            w_load       = 1'b1;
            w_state_next = ST_SETUP;
          end else begin
            w_err_next = 1'b1;
          end
        end
      end
      ST_SETUP: begin
        if (w_done) begin
          w_state_next = ST_OPEN;
          w_load       = 1'b1;
          w_load_val   = CW'(PULSE_CYC);
          w_gaten_next = ~w_sel;
        end
      end
      ST_OPEN: begin
        w_gaten_next = ~w_sel;
        if (w_done) begin
          w_state_next = ST_HOLD;
          w_load       = 1'b1;
          w_load_val   = CW'(HOLD_CYC);
          w_gaten_next = GATEN_ALL_CLOSED;
        end
      end
      ST_HOLD: begin
        if (w_done) begin
          w_state_next = ST_IDLE;
        end
      end
    endcase
    w_ready_next = (w_state_next == ST_IDLE);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_dbus  <= '0;
      r_gaten <= GATEN_ALL_CLOSED;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_addr  <= w_addr_next;
      r_dbus  <= w_dbus_next;
      r_gaten <= w_gaten_next;
      r_ready <= w_ready_next;
      r_err   <= w_err_next;
    end
  end

  assign WR_READY = r_ready;
  assign WR_ERR   = r_err;
  assign D_BUS    = r_dbus;
  assign GATEN    = r_gaten;

endmodule
